seq_detect_scheduler: RTL

//   Shares one serial sequence-detector FSM (input w, synchronous clear, level hit output) among NREQ requesters.

---
 rtl/seq_detect_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
// Shares one serial sequence-detector among NREQ requesters. A round-robin
// arbiter picks a job word, the detector is cleared, the word is shifted in
// MSB first, and the number of detector hits seen after each shifted bit is
// returned together with a one-cycle done pulse.
module seq_detect_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         grant,
    input  logic                    step_en,
    output logic                    det_clr,
    output logic                    det_en,
    output logic                    det_w,
    input  logic                    det_hit,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [CNT_W-1:0]        hit_count
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int BIT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [BIT_W-1:0] bitCnt_q,   bitCnt_d;
    logic [ID_W-1:0]  jobId_q,    jobId_d;
    logic [ID_W-1:0]  rrPtr_q,    rrPtr_d;
    logic [CNT_W-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] hitCount_q, hitCount_d;
    logic             valid_q,    valid_d;

    logic             grantValid;
    logic [ID_W-1:0]  grantIdx;
    logic             sampleHit;

    // Round-robin pick: the first active request after the last-served requester.
    always_comb begin
        int cand;
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(rrPtr_q) + i) % NREQ;
            if (!grantValid && req[ID_W'(cand)]) begin
                grantValid = 1'b1;
                grantIdx   = ID_W'(cand);
            end
        end
    end

    // Job sequencing: next-state, datapath updates and detector-facing outputs.
    // The result register is loaded on entry to DONE so hit_count is already
    // valid during the done pulse, including the sample taken in DRAIN.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitCnt_d   = bitCnt_q;
        jobId_d    = jobId_q;
        rrPtr_d    = rrPtr_q;
        acc_d      = acc_q;
        hitCount_d = hitCount_q;
        grant      = '0;
        det_clr    = reset;
        det_en     = 1'b0;
        det_w      = 1'b0;
        done       = 1'b0;

        sampleHit = valid_q && det_hit && ((state_q == SHIFT) || (state_q == DRAIN));
        if (sampleHit && (acc_q != {CNT_W{1'b1}})) begin
            acc_d = acc_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (grantValid && !reset) begin
                    grant      = NREQ'(1) << grantIdx;
                    shiftReg_d = req_data[int'(grantIdx)*WIDTH +: WIDTH];
                    jobId_d    = grantIdx;
                    rrPtr_d    = grantIdx;
                    acc_d      = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                det_clr  = 1'b1;
                bitCnt_d = BIT_W'(WIDTH);
                state_d  = SHIFT;
            end
            SHIFT: begin
                det_w = shiftReg_q[WIDTH-1];
                if (step_en) begin
                    det_en     = 1'b1;
                    shiftReg_d = shiftReg_q << 1;
                    bitCnt_d   = bitCnt_q - BIT_W'(1);
                    if (bitCnt_q == BIT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                hitCount_d = acc_d;
                state_d    = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = det_en;
    end

    // State and datapath registers with synchronous reset back to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            jobId_q    <= '0;
            rrPtr_q    <= ID_W'(NREQ - 1);
            acc_q      <= '0;
            hitCount_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_d;
            jobId_q    <= jobId_d;
            rrPtr_q    <= rrPtr_d;
            acc_q      <= acc_d;
            hitCount_q <= hitCount_d;
            valid_q    <= valid_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done_id   = jobId_q;
    assign hit_count = hitCount_q;

endmodule
